// File: rtl/sobel_addr_gen.sv
// sobel_addr_gen: 3x3 window address sequencer for a Sobel filter.
//
// On start, walks every interior pixel (r,c) of a width x length image.
// For each pixel it issues nine read addresses covering the 3x3
// neighbourhood in row-major order, then one write address for the result.
// Results are stored densely as a (W-2)x(L-2) row-major image.
//
// Ports:
//   HCLK, HRESET        clock (rising edge), asynchronous active-low reset
//   start               begin-frame request, sampled only in IDLE
//   width, length       image dimensions in pixels, latched on start
//   initial_addr_r/_w   8-bit source/destination bases, shifted by BASE_SHIFT
//   rd_req/rd_addr      read request and pixel address
//   win_idx             window position 0..8 of the current read
//   rd_ack              read accepted; ignored unless rd_req
//   wr_req/wr_addr      write request and output pixel address
//   wr_ack              write accepted; ignored unless wr_req
//   busy                frame in progress
//   done                one-cycle end-of-frame pulse
//   size_err            sticky flag: last accepted start had width<3 or length<3

module sobel_addr_gen #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned BASE_SHIFT = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              start,
    input  logic [11:0]       width,
    input  logic [11:0]       length,
    input  logic [7:0]        initial_addr_r,
    input  logic [7:0]        initial_addr_w,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        win_idx,
    input  logic              rd_ack,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ack,
    output logic              busy,
    output logic              done,
    output logic              size_err
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [11:0]       w_q, w_d;
    logic [11:0]       l_q, l_d;
    logic [ADDR_W-1:0] base_r_q, base_r_d;
    logic [ADDR_W-1:0] base_w_q, base_w_d;
    logic [11:0]       r_q, r_d;
    logic [11:0]       c_q, c_d;
    logic [3:0]        k_q, k_d;
    // Column within the current window row (k % 3), kept to avoid a divider.
    logic [1:0]        kcol_q, kcol_d;
    // Offset of the window's top-left pixel: (r-1)*W + (c-1).
    logic [23:0]       win_base_q, win_base_d;
    // Offset of pixel k inside the window: (k/3)*W + k%3.
    logic [23:0]       k_off_q, k_off_d;
    logic [23:0]       out_idx_q, out_idx_d;
    logic              size_err_q, size_err_d;

    logic last_col;
    logic last_row;

    assign last_col = (c_q == w_q - 12'd2);
    assign last_row = (r_q == l_q - 12'd2);

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        l_d        = l_q;
        base_r_d   = base_r_q;
        base_w_d   = base_w_q;
        r_d        = r_q;
        c_d        = c_q;
        k_d        = k_q;
        kcol_d     = kcol_q;
        win_base_d = win_base_q;
        k_off_d    = k_off_q;
        out_idx_d  = out_idx_q;
        size_err_d = size_err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    w_d        = width;
                    l_d        = length;
                    base_r_d   = {{(ADDR_W-8){1'b0}}, initial_addr_r} << BASE_SHIFT;
                    base_w_d   = {{(ADDR_W-8){1'b0}}, initial_addr_w} << BASE_SHIFT;
                    r_d        = 12'd1;
                    c_d        = 12'd1;
                    k_d        = 4'd0;
                    kcol_d     = 2'd0;
                    win_base_d = 24'd0;
                    k_off_d    = 24'd0;
                    out_idx_d  = 24'd0;
                    if (width < 12'd3 || length < 12'd3) begin
                        size_err_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        size_err_d = 1'b0;
                        state_d    = StRead;
                    end
                end
            end

            StRead: begin
                if (rd_ack) begin
                    if (k_q == 4'd8) begin
                        state_d = StWrite;
                    end else begin
                        k_d = k_q + 4'd1;
                        if (kcol_q == 2'd2) begin
                            // Step from the end of one window row to the start of the next.
                            kcol_d  = 2'd0;
                            k_off_d = k_off_q + {12'd0, w_q} - 24'd2;
                        end else begin
                            kcol_d  = kcol_q + 2'd1;
                            k_off_d = k_off_q + 24'd1;
                        end
                    end
                end
            end

            StWrite: begin
                if (wr_ack) begin
                    if (last_col && last_row) begin
                        state_d = StDone;
                    end else begin
                        out_idx_d = out_idx_q + 24'd1;
                        k_d       = 4'd0;
                        kcol_d    = 2'd0;
                        k_off_d   = 24'd0;
                        state_d   = StRead;
                        if (last_col) begin
                            // Top-left moves from column W-3 of row r-1 to column 0 of row r.
                            c_d        = 12'd1;
                            r_d        = r_q + 12'd1;
                            win_base_d = win_base_q + 24'd3;
                        end else begin
                            c_d        = c_q + 12'd1;
                            win_base_d = win_base_q + 24'd1;
                        end
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q    <= StIdle;
            w_q        <= 12'd0;
            l_q        <= 12'd0;
            base_r_q   <= '0;
            base_w_q   <= '0;
            r_q        <= 12'd0;
            c_q        <= 12'd0;
            k_q        <= 4'd0;
            kcol_q     <= 2'd0;
            win_base_q <= 24'd0;
            k_off_q    <= 24'd0;
            out_idx_q  <= 24'd0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            l_q        <= l_d;
            base_r_q   <= base_r_d;
            base_w_q   <= base_w_d;
            r_q        <= r_d;
            c_q        <= c_d;
            k_q        <= k_d;
            kcol_q     <= kcol_d;
            win_base_q <= win_base_d;
            k_off_q    <= k_off_d;
            out_idx_q  <= out_idx_d;
            size_err_q <= size_err_d;
        end
    end

    // Outputs are decoded from state so that reset clears them without waiting for a clock.
    always_comb begin
        rd_req   = (state_q == StRead);
        wr_req   = (state_q == StWrite);
        busy     = (state_q == StRead) || (state_q == StWrite);
        done     = (state_q == StDone);
        size_err = size_err_q;
        rd_addr  = '0;
        win_idx  = 4'd0;
        wr_addr  = '0;
        if (state_q == StRead) begin
            rd_addr = base_r_q + ADDR_W'(win_base_q + k_off_q);
            win_idx = k_q;
        end
        if (state_q == StWrite) begin
            wr_addr = base_w_q + ADDR_W'(out_idx_q);
        end
    end

endmodule
